hazard_tracker: RTL and testbench

- Consumes the per-instruction register addresses produced by the D-stage decoder: A1/A2 as sources and A3 as destination, plus Tuse/Tnew timing.
- Keeps a scoreboard of destination registers and their Tnew for the E, M and W stages.
- Generates the pipeline stall and the forwarding-mux selects for D-stage, E-stage and M-stage operands.
- Sits beside the datapath of the 5-stage MIPS core and is the single source of stall/forward control.

---
 rtl/hazard_tracker.sv | 163 ++++++++++++++++
 tb/tb_hazard_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tracker
// Purpose  : Stall and forwarding control for a 5-stage MIPS pipeline.
//            Tracks the destination register and result-ready time (tnew)
//            of the instructions in the E, M and W stages. These are
//            compared with the D-stage source registers and their
//            need-time (tuse).
// Ports    : clk             core clock, rising edge
//            reset           asynchronous, active-low reset
//            d_a1/d_a2       D-stage source register addresses (0 = unused)
//            d_tuse1/2       cycles after D until the source is needed (3 = never)
//            d_a3            D-stage destination register (0 = no write)
//            d_tnew          cycles after entering E until the result is ready
//            stall           freeze F/D, bubble into E
//            fwd_d1/fwd_d2   D operand select: 0 GRF, 1 E, 2 M, 3 W
//            fwd_e1/fwd_e2   E operand select: 0 pipe reg, 2 M, 3 W
//            fwd_m2          M store-data select: 0 pipe reg, 1 W
// Revision : 1.0  initial release
// ============================================================================
module hazard_tracker #(
  parameter int ADDR_W = 5,
  parameter int T_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] d_a1,
  input  logic [ADDR_W-1:0] d_a2,
  input  logic [T_W-1:0]    d_tuse1,
  input  logic [T_W-1:0]    d_tuse2,
  input  logic [ADDR_W-1:0] d_a3,
  input  logic [T_W-1:0]    d_tnew,
  output logic              stall,
  output logic [1:0]        fwd_d1,
  output logic [1:0]        fwd_d2,
  output logic [1:0]        fwd_e1,
  output logic [1:0]        fwd_e2,
  output logic              fwd_m2
);

  // Forwarding select encodings
  localparam logic [1:0] c_SEL_REG = 2'd0;
  localparam logic [1:0] c_SEL_E   = 2'd1;
  localparam logic [1:0] c_SEL_M   = 2'd2;
  localparam logic [1:0] c_SEL_W   = 2'd3;

  // --------------------------------------------------------------------------
  // Stage scoreboard
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] r_e_a1;
  logic [ADDR_W-1:0] r_e_a2;
  logic [ADDR_W-1:0] r_e_a3;
  logic [T_W-1:0]    r_e_tnew;
  logic [ADDR_W-1:0] r_m_a2;
  logic [ADDR_W-1:0] r_m_a3;
  logic [T_W-1:0]    r_m_tnew;
  logic [ADDR_W-1:0] r_w_a3;
  logic [T_W-1:0]    r_w_tnew;

  // Saturating decrement: a result that is already available stays at 0.
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t != '0) ? (t - T_W'(1)) : '0;
  endfunction

  // --------------------------------------------------------------------------
  // Per-source hazard evaluation (index 0 = rs, index 1 = rt)
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic [ADDR_W-1:0] w_d_a;
    logic [T_W-1:0]    w_tuse;
    logic [ADDR_W-1:0] w_e_a;
    logic              w_d_hit_e;
    logic              w_d_hit_m;
    logic              w_d_hit_w;
    logic              w_e_hit_m;
    logic              w_e_hit_w;
    logic              w_stall;
    logic [1:0]        w_fwd_d;
    logic [1:0]        w_fwd_e;

    assign w_d_a  = (gi == 0) ? d_a1    : d_a2;
    assign w_tuse = (gi == 0) ? d_tuse1 : d_tuse2;
    assign w_e_a  = (gi == 0) ? r_e_a1  : r_e_a2;

    // $0 is hard-wired zero, so it never matches a producer.
    assign w_d_hit_e = (w_d_a != '0) && (r_e_a3 == w_d_a);
    assign w_d_hit_m = (w_d_a != '0) && (r_m_a3 == w_d_a);
    assign w_d_hit_w = (w_d_a != '0) && (r_w_a3 == w_d_a);
    assign w_e_hit_m = (w_e_a != '0) && (r_m_a3 == w_e_a);
    assign w_e_hit_w = (w_e_a != '0) && (r_w_a3 == w_e_a);

    // D stage: only the nearest producer counts. Stall when its result
    // arrives later than the consumer needs it; forward only once ready.
    always_comb begin
      w_stall = 1'b0;
      w_fwd_d = c_SEL_REG;
      if (w_d_hit_e) begin
        w_stall = (r_e_tnew > w_tuse);
        if (r_e_tnew == '0) w_fwd_d = c_SEL_E;
      end else if (w_d_hit_m) begin
        w_stall = (r_m_tnew > w_tuse);
        if (r_m_tnew == '0) w_fwd_d = c_SEL_M;
      end else if (w_d_hit_w) begin
        w_stall = (r_w_tnew > w_tuse);
        if (r_w_tnew == '0) w_fwd_d = c_SEL_W;
      end
    end

    // E stage: an M producer that is not ready yet shadows W. The value
    // selected then is never consumed because the D-stage stall held it.
    always_comb begin
      w_fwd_e = c_SEL_REG;
      if (w_e_hit_m) begin
        if (r_m_tnew == '0) w_fwd_e = c_SEL_M;
      end else if (w_e_hit_w) begin
        w_fwd_e = c_SEL_W;
      end
    end
  end

  assign stall  = g_src[0].w_stall | g_src[1].w_stall;
  assign fwd_d1 = g_src[0].w_fwd_d;
  assign fwd_d2 = g_src[1].w_fwd_d;
  assign fwd_e1 = g_src[0].w_fwd_e;
  assign fwd_e2 = g_src[1].w_fwd_e;
  assign fwd_m2 = (r_m_a2 != '0) && (r_w_a3 == r_m_a2);

  // --------------------------------------------------------------------------
  // Scoreboard advance. A stall only bubbles E; M and W always drain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_e_a1   <= '0;
      r_e_a2   <= '0;
      r_e_a3   <= '0;
      r_e_tnew <= '0;
      r_m_a2   <= '0;
      r_m_a3   <= '0;
      r_m_tnew <= '0;
      r_w_a3   <= '0;
      r_w_tnew <= '0;
    end else begin
      if (stall) begin
        r_e_a1   <= '0;
        r_e_a2   <= '0;
        r_e_a3   <= '0;
        r_e_tnew <= '0;
      end else begin
        r_e_a1   <= d_a1;
        r_e_a2   <= d_a2;
        r_e_a3   <= d_a3;
        r_e_tnew <= d_tnew;
      end
      r_m_a2   <= r_e_a2;
      r_m_a3   <= r_e_a3;
      r_m_tnew <= sat_dec(r_e_tnew);
      r_w_a3   <= r_m_a3;
      r_w_tnew <= sat_dec(r_m_tnew);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_tracker
// Purpose  : Self-checking bench for hazard_tracker. It uses directed
//            instruction sequences followed by random traffic. The
//            reference model holds the in-flight instructions as a small
//            array.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_a1, d_a2, d_a3;
  logic [1:0] d_tuse1, d_tuse2, d_tnew;
  logic       stall;
  logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;
  logic       fwd_m2;

  always #5 clk = ~clk;

  hazard_tracker #(.ADDR_W(5), .T_W(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .d_a1    (d_a1),
    .d_a2    (d_a2),
    .d_tuse1 (d_tuse1),
    .d_tuse2 (d_tuse2),
    .d_a3    (d_a3),
    .d_tnew  (d_tnew),
    .stall   (stall),
    .fwd_d1  (fwd_d1),
    .fwd_d2  (fwd_d2),
    .fwd_e1  (fwd_e1),
    .fwd_e2  (fwd_e2),
    .fwd_m2  (fwd_m2)
  );

  // In-flight instructions: index 0 = E, 1 = M, 2 = W.
  // tnew = cycles until the result exists.
  typedef struct {
    int a1;
    int a2;
    int a3;
    int tnew;
  } ent_t;

  ent_t pipe[3];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   m_stall = 0;

  function automatic int nearest(int x);
    if (x == 0) return -1;
    for (int s = 0; s < 3; s++) if (pipe[s].a3 == x) return s;
    return -1;
  endfunction

  function automatic int exp_stall(int x, int tuse);
    int s = nearest(x);
    return (s >= 0 && pipe[s].tnew > tuse) ? 1 : 0;
  endfunction

  function automatic int exp_fwd_d(int x);
    int s = nearest(x);
    return (s >= 0 && pipe[s].tnew == 0) ? s + 1 : 0;
  endfunction

  function automatic int exp_fwd_e(int x);
    if (x == 0) return 0;
    if (pipe[1].a3 == x) return (pipe[1].tnew == 0) ? 2 : 0;
    if (pipe[2].a3 == x) return 3;
    return 0;
  endfunction

  function automatic int exp_fwd_m2();
    return (pipe[1].a2 != 0 && pipe[2].a3 == pipe[1].a2) ? 1 : 0;
  endfunction

  function automatic int dec(int t);
    return (t > 0) ? t - 1 : 0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) pipe[s] = '{0, 0, 0, 0};
  endtask

  task automatic advance(int stl);
    pipe[2] = '{pipe[1].a1, pipe[1].a2, pipe[1].a3, dec(pipe[1].tnew)};
    pipe[1] = '{pipe[0].a1, pipe[0].a2, pipe[0].a3, dec(pipe[0].tnew)};
    if (stl != 0) pipe[0] = '{0, 0, 0, 0};
    else pipe[0] = '{int'(d_a1), int'(d_a2), int'(d_a3), int'(d_tnew)};
  endtask

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all();
    m_stall = exp_stall(int'(d_a1), int'(d_tuse1)) | exp_stall(int'(d_a2), int'(d_tuse2));
    chk("stall", int'(stall), m_stall);
    if (m_stall == 0) begin
      chk("fwd_d1", int'(fwd_d1), exp_fwd_d(int'(d_a1)));
      chk("fwd_d2", int'(fwd_d2), exp_fwd_d(int'(d_a2)));
    end
    chk("fwd_e1", int'(fwd_e1), exp_fwd_e(pipe[0].a1));
    chk("fwd_e2", int'(fwd_e2), exp_fwd_e(pipe[0].a2));
    chk("fwd_m2", int'(fwd_m2), exp_fwd_m2());
  endtask

  // Present one D-stage instruction and check the combinational outputs.
  task automatic drive(int a1, int a2, int t1, int t2, int a3, int tn);
    d_a1 = 5'(a1); d_a2 = 5'(a2); d_tuse1 = 2'(t1); d_tuse2 = 2'(t2);
    d_a3 = 5'(a3); d_tnew = 2'(tn);
    #1;
    chk_all();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    advance(m_stall);
  endtask

  task automatic nop();
    drive(0, 0, 3, 3, 0, 0);
    tick();
  endtask

  task automatic flush();
    repeat (3) nop();
  endtask

  int ra1, ra2, rt1, rt2, ra3, rtn;

  initial begin
    reset = 1'b0;
    d_a1 = '0; d_a2 = '0; d_a3 = '0; d_tuse1 = 2'd3; d_tuse2 = 2'd3; d_tnew = '0;
    model_clear();
    #1;
    chk_all();
    chk("reset_stall", int'(stall), 0);
    #12 reset = 1'b1;
    tick();

    // lw $1 followed by addu $2,$1,$3: one-cycle load-use stall, then W forward
    drive(29, 0, 1, 3, 1, 2); tick();
    drive(1, 3, 1, 1, 2, 1);
    chk("lw_use_stall", int'(stall), 1);
    tick();
    drive(1, 3, 1, 1, 2, 1);
    chk("lw_use_release", int'(stall), 0);
    tick();
    drive(0, 0, 3, 3, 0, 0);
    chk("lw_fwd_e1_w", int'(fwd_e1), 3);
    tick();

    // ori $5 ; addu $6,$5,$5: no stall, both E operands from M
    flush();
    drive(0, 0, 1, 3, 5, 1); tick();
    drive(5, 5, 1, 1, 6, 1);
    chk("ori_no_stall", int'(stall), 0);
    tick();
    drive(0, 0, 3, 3, 0, 0);
    chk("ori_fwd_e1_m", int'(fwd_e1), 2);
    chk("ori_fwd_e2_m", int'(fwd_e2), 2);
    tick();

    // addu $4 ; beq $4,$0: one-cycle branch stall, then D forward from M
    flush();
    drive(0, 0, 1, 1, 4, 1); tick();
    drive(4, 0, 0, 0, 0, 0);
    chk("beq_stall", int'(stall), 1);
    tick();
    drive(4, 0, 0, 0, 0, 0);
    chk("beq_release", int'(stall), 0);
    chk("beq_fwd_d1_m", int'(fwd_d1), 2);
    chk("beq_fwd_d2", int'(fwd_d2), 0);
    tick();

    // jal ; jr $31: forward straight from E
    flush();
    drive(0, 0, 3, 3, 31, 0); tick();
    drive(31, 0, 0, 3, 0, 0);
    chk("jr_no_stall", int'(stall), 0);
    chk("jr_fwd_d1_e", int'(fwd_d1), 1);
    tick();

    // Writes to $0 never create hazards
    flush();
    drive(0, 0, 1, 3, 0, 1); tick();
    drive(0, 0, 1, 3, 0, 2); tick();
    drive(0, 0, 0, 0, 8, 1);
    chk("r0_stall", int'(stall), 0);
    chk("r0_fwd_d1", int'(fwd_d1), 0);
    tick();
    drive(0, 0, 3, 3, 0, 0);
    chk("r0_fwd_e1", int'(fwd_e1), 0);
    chk("r0_fwd_m2", int'(fwd_m2), 0);
    tick();

    // lw $7 ; sw $7: no stall, store data forwarded from W at M
    flush();
    drive(29, 0, 1, 3, 7, 2); tick();
    drive(29, 7, 1, 2, 0, 0);
    chk("sw_no_stall", int'(stall), 0);
    tick();
    nop();
    drive(0, 0, 3, 3, 0, 0);
    chk("sw_fwd_m2", int'(fwd_m2), 1);
    tick();

    // Reset asserted while stalled flushes the scoreboard immediately
    flush();
    drive(29, 0, 1, 3, 1, 2); tick();
    drive(0, 0, 1, 3, 9, 1); tick();
    drive(1, 9, 0, 0, 0, 0);
    chk("rst_pre_stall", int'(stall), 1);
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_stall_drop", int'(stall), 0);
    chk("rst_e_a3", int'(dut.r_e_a3), 0);
    chk("rst_m_a3", int'(dut.r_m_a3), 0);
    chk("rst_m_tnew", int'(dut.r_m_tnew), 0);
    chk("rst_w_a3", int'(dut.r_w_a3), 0);
    #2 reset = 1'b1;
    #1;
    chk_all();
    chk("rst_after_stall", int'(stall), 0);
    chk("rst_after_fwd_d1", int'(fwd_d1), 0);
    tick();

    // Random traffic; a stalled instruction is held in D until released
    ra1 = 0; ra2 = 0; rt1 = 3; rt2 = 3; ra3 = 0; rtn = 0;
    for (int k = 0; k < 400; k++) begin
      if (m_stall == 0) begin
        ra1 = int'($urandom_range(0, 7));
        ra2 = ($urandom_range(0, 3) == 0) ? ra1 : int'($urandom_range(0, 7));
        rt1 = int'($urandom_range(0, 3));
        rt2 = int'($urandom_range(0, 3));
        ra3 = int'($urandom_range(0, 7));
        rtn = int'($urandom_range(0, 2));
      end
      drive(ra1, ra2, rt1, rt2, ra3, rtn);
      if (ra1 == ra2 && rt1 == rt2 && m_stall == 0)
        chk("same_src_fwd_d", int'(fwd_d1), int'(fwd_d2));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
